// File: rtl/controlador_exploracao_if.sv
// Bundle between the exploration sequencer, navigation and the frontier-search datapath.
// The master side is the sequencer; the slave side is navigation plus datapath.
interface controlador_exploracao_if #(
    parameter int tamanhoDistancia = 8
);
    logic                        pedido;
    logic [tamanhoDistancia-1:0] posX;
    logic [tamanhoDistancia-1:0] posY;
    logic                        busca_finalizada;
    logic [tamanhoDistancia-1:0] buscaX;
    logic [tamanhoDistancia-1:0] buscaY;
    logic                        reset_busca;
    logic                        novo_dado;
    logic [3:0]                  enable_quadrantes;
    logic [tamanhoDistancia-1:0] posBuscaX;
    logic [tamanhoDistancia-1:0] posBuscaY;
    logic                        destino_valido;
    logic                        destino_pronto;
    logic [tamanhoDistancia-1:0] destinoX;
    logic [tamanhoDistancia-1:0] destinoY;
    logic                        sem_fronteira;
    logic                        erro_timeout;
    logic                        ocupado;
    logic [15:0]                 contador_buscas;

    modport master (
        input  pedido, posX, posY, busca_finalizada, buscaX, buscaY, destino_pronto,
        output reset_busca, novo_dado, enable_quadrantes, posBuscaX, posBuscaY,
               destino_valido, destinoX, destinoY, sem_fronteira, erro_timeout,
               ocupado, contador_buscas
    );

    modport slave (
        output pedido, posX, posY, busca_finalizada, buscaX, buscaY, destino_pronto,
        input  reset_busca, novo_dado, enable_quadrantes, posBuscaX, posBuscaY,
               destino_valido, destinoX, destinoY, sem_fronteira, erro_timeout,
               ocupado, contador_buscas
    );
endinterface

// File: rtl/controlador_exploracao.sv
// Sequencer for the quadrant frontier search: primary mask first, secondary mask on an empty
// result, then delivers a destination over valid/ready or reports no-frontier / timeout.
module controlador_exploracao #(
    parameter int         tamanhoDistancia   = 8,
    parameter int         TIMEOUT_CICLOS     = 4096,
    parameter logic [3:0] MASCARA_PRIMARIA   = 4'b1100,
    parameter logic [3:0] MASCARA_SECUNDARIA = 4'b0011
) (
    input logic                     clock,
    input logic                     reset,
    controlador_exploracao_if.master bus
);
    localparam int larguraTimeout = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [larguraTimeout-1:0] limiteTimeout = larguraTimeout'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        LIMPAR,
        DISPARAR,
        AGUARDAR,
        AVALIAR,
        ENTREGAR,
        FIM
    } tipoEstado;

    tipoEstado                 estado;
    logic                      tentativa;
    logic [larguraTimeout-1:0] contadorTimeout;

    // An empty search leaves the datapath's answer sitting on the robot pose.
    logic semCandidato;
    assign semCandidato = (bus.buscaX == bus.posBuscaX) && (bus.buscaY == bus.posBuscaY);

    // NOTE: every register here, outputs included, is state and is written with <= only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado                <= OCIOSO;
            tentativa             <= 1'b0;
            contadorTimeout       <= '0;
            bus.reset_busca       <= 1'b0;
            bus.novo_dado         <= 1'b0;
            bus.enable_quadrantes <= 4'b0000;
            bus.posBuscaX         <= '0;
            bus.posBuscaY         <= '0;
            bus.destino_valido    <= 1'b0;
            bus.destinoX          <= '0;
            bus.destinoY          <= '0;
            bus.sem_fronteira     <= 1'b0;
            bus.erro_timeout      <= 1'b0;
            bus.ocupado           <= 1'b0;
            bus.contador_buscas   <= 16'h0000;
        end else begin
            // NOTE: pulse outputs default low so each state only raises what it owns.
            bus.reset_busca   <= 1'b0;
            bus.novo_dado     <= 1'b0;
            bus.sem_fronteira <= 1'b0;
            bus.erro_timeout  <= 1'b0;

            unique case (estado)
                OCIOSO: begin
                    if (bus.pedido) begin
                        bus.posBuscaX         <= bus.posX;
                        bus.posBuscaY         <= bus.posY;
                        bus.enable_quadrantes <= MASCARA_PRIMARIA;
                        tentativa             <= 1'b0;
                        bus.reset_busca       <= 1'b1;
                        bus.ocupado           <= 1'b1;
                        estado                <= LIMPAR;
                    end
                end
                LIMPAR: begin
                    contadorTimeout <= '0;
                    bus.novo_dado   <= 1'b1;
                    if (bus.contador_buscas != 16'hFFFF) begin
                        bus.contador_buscas <= bus.contador_buscas + 16'd1;
                    end
                    estado <= DISPARAR;
                end
                DISPARAR: begin
                    estado <= AGUARDAR;
                end
                AGUARDAR: begin
                    // Completion is checked first so it wins over a timeout in the same cycle.
                    if (bus.busca_finalizada) begin
                        estado <= AVALIAR;
                    end else if (contadorTimeout == limiteTimeout) begin
                        bus.erro_timeout      <= 1'b1;
                        bus.enable_quadrantes <= 4'b0000;
                        estado                <= FIM;
                    end else begin
                        contadorTimeout <= contadorTimeout + 1'b1;
                    end
                end
                AVALIAR: begin
                    if (!semCandidato) begin
                        bus.destinoX          <= bus.buscaX;
                        bus.destinoY          <= bus.buscaY;
                        bus.destino_valido    <= 1'b1;
                        bus.enable_quadrantes <= 4'b0000;
                        estado                <= ENTREGAR;
                    end else if (!tentativa) begin
                        tentativa             <= 1'b1;
                        bus.enable_quadrantes <= MASCARA_SECUNDARIA;
                        bus.reset_busca       <= 1'b1;
                        estado                <= LIMPAR;
                    end else begin
                        bus.sem_fronteira     <= 1'b1;
                        bus.enable_quadrantes <= 4'b0000;
                        estado                <= FIM;
                    end
                end
                ENTREGAR: begin
                    if (bus.destino_pronto) begin
                        bus.destino_valido <= 1'b0;
                        bus.ocupado        <= 1'b0;
                        estado             <= OCIOSO;
                    end
                end
                FIM: begin
                    bus.ocupado <= 1'b0;
                    estado      <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_exploracao.sv
// Randomized bench for controlador_exploracao: each request is turned into an expected
// per-cycle output timeline computed from the search outcomes, then replayed cycle by cycle.
module tb_controlador_exploracao;
    localparam int T     = 16;
    localparam int MAXC  = 128;
    localparam int NUNCA = 1000;

    typedef struct packed {
        logic       ocupado;
        logic       resetBusca;
        logic       novoDado;
        logic [3:0] enable;
        logic       valido;
        logic       semFronteira;
        logic       erroTimeout;
    } saidas_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    controlador_exploracao_if #(.tamanhoDistancia(8)) barramento ();

    controlador_exploracao #(
        .tamanhoDistancia  (8),
        .TIMEOUT_CICLOS    (T),
        .MASCARA_PRIMARIA  (4'b1100),
        .MASCARA_SECUNDARIA(4'b0011)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (barramento)
    );

    int      vetores      = 0;
    int      erros        = 0;
    int      contEsperado = 0;
    saidas_t linhaTempo[MAXC];

    task automatic verificar(input string tag, input logic [63:0] obtido, input logic [63:0] esperado);
        vetores++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obtido, esperado, $time);
        end
    endtask

    function automatic saidas_t observar();
        saidas_t s;
        s.ocupado      = barramento.ocupado;
        s.resetBusca   = barramento.reset_busca;
        s.novoDado     = barramento.novo_dado;
        s.enable       = barramento.enable_quadrantes;
        s.valido       = barramento.destino_valido;
        s.semFronteira = barramento.sem_fronteira;
        s.erroTimeout  = barramento.erro_timeout;
        return s;
    endfunction

    function automatic logic [63:0] todasSaidas();
        return 64'({observar(), barramento.destinoX, barramento.destinoY,
                    barramento.posBuscaX, barramento.posBuscaY, barramento.contador_buscas});
    endfunction

    function automatic logic [3:0] mascaraDaBusca(input int b);
        return (b == 0) ? 4'b1100 : 4'b0011;
    endfunction

    // One navigation request. nK is the AGUARDAR cycle on which search K reports done
    // (above T means never); resetEm >= 0 asserts reset at that relative cycle.
    task automatic transacao(input logic [7:0] px, input logic [7:0] py,
                             input logic [7:0] r1x, input logic [7:0] r1y, input int n1,
                             input logic [7:0] r2x, input logic [7:0] r2y, input int n2,
                             input int atraso, input bit espurio, input int resetEm);
        logic [7:0] resX[2];
        logic [7:0] resY[2];
        int         resN[2];
        logic [7:0] dx, dy;
        int         d, tEnd, tValido, nBuscas, idxBusca, atual, k;
        bit         rodando, fin;

        resX[0] = r1x; resY[0] = r1y; resN[0] = n1;
        resX[1] = r2x; resY[1] = r2y; resN[1] = n2;

        foreach (linhaTempo[i]) linhaTempo[i] = '0;
        d = 2; tValido = -1; tEnd = 0; nBuscas = 0; dx = 8'd0; dy = 8'd0;
        for (int b = 0; b < 2; b++) begin
            nBuscas++;
            linhaTempo[d-1].resetBusca = 1'b1;
            linhaTempo[d].novoDado     = 1'b1;
            if (resN[b] > T) begin
                for (int i = d - 1; i <= d + T; i++) linhaTempo[i].enable = mascaraDaBusca(b);
                tEnd = d + T + 1;
                linhaTempo[tEnd].erroTimeout = 1'b1;
                break;
            end
            for (int i = d - 1; i <= d + resN[b] + 1; i++) linhaTempo[i].enable = mascaraDaBusca(b);
            if (resX[b] != px || resY[b] != py) begin
                tValido = d + resN[b] + 2;
                tEnd    = tValido + atraso;
                for (int i = tValido; i <= tEnd; i++) linhaTempo[i].valido = 1'b1;
                dx = resX[b];
                dy = resY[b];
                break;
            end
            if (b == 1) begin
                tEnd = d + resN[b] + 2;
                linhaTempo[tEnd].semFronteira = 1'b1;
            end
            d = d + resN[b] + 3;
        end
        for (int i = 1; i <= tEnd; i++) linhaTempo[i].ocupado = 1'b1;

        rodando = 1'b0; fin = 1'b0; idxBusca = 0; atual = 0; k = 0;
        for (int c = 0; c <= tEnd + 2; c++) begin
            @(negedge clock);
            verificar($sformatf("outputs c%0d", c), 64'(observar()), 64'(linhaTempo[c]));
            if (linhaTempo[c].valido)
                verificar("destino", 64'({barramento.destinoX, barramento.destinoY}), 64'({dx, dy}));
            if (linhaTempo[c].novoDado)
                verificar("posBusca", 64'({barramento.posBuscaX, barramento.posBuscaY}), 64'({px, py}));

            if (c == resetEm) begin
                reset = 1'b1;
                #1;
                verificar("reset abort", todasSaidas(), 64'd0);
                barramento.pedido           = 1'b0;
                barramento.destino_pronto   = 1'b0;
                barramento.busca_finalizada = 1'b0;
                repeat (2) begin
                    @(negedge clock);
                    verificar("held in reset", todasSaidas(), 64'd0);
                end
                reset = 1'b0;
                contEsperado = 0;
                return;
            end

            // Datapath: sticky done flag, cleared by reset_busca, raised N cycles after novo_dado.
            if (barramento.reset_busca) begin
                rodando = 1'b0;
                fin     = 1'b0;
            end
            if (barramento.novo_dado) begin
                rodando = 1'b1;
                k       = 0;
                atual   = (idxBusca < 2) ? idxBusca : 1;
                idxBusca++;
                barramento.buscaX = resX[atual];
                barramento.buscaY = resY[atual];
            end else if (rodando) begin
                k++;
                if (k == resN[atual]) fin = 1'b1;
            end
            barramento.busca_finalizada = fin;

            // Navigation side, with optional stray pedido/pose/pronto while the controller is busy.
            barramento.pedido = (c == 0) || (espurio && c <= tEnd && $urandom_range(0, 1) == 1);
            if (c == 0) begin
                barramento.posX = px;
                barramento.posY = py;
            end else if (espurio) begin
                barramento.posX = 8'($urandom);
                barramento.posY = 8'($urandom);
            end
            barramento.destino_pronto = (tValido >= 0 && c == tEnd) ||
                                        (espurio && c <= tEnd && (tValido < 0 || c < tValido) &&
                                         $urandom_range(0, 1) == 1);
        end

        contEsperado = (contEsperado + nBuscas > 65535) ? 65535 : contEsperado + nBuscas;
        verificar("contador_buscas", 64'(barramento.contador_buscas), 64'(contEsperado));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] px, py, r1x, r1y, r2x, r2y;
        int         n1, n2, resetEm;

        barramento.pedido           = 1'b0;
        barramento.posX             = 8'd0;
        barramento.posY             = 8'd0;
        barramento.busca_finalizada = 1'b0;
        barramento.buscaX           = 8'd0;
        barramento.buscaY           = 8'd0;
        barramento.destino_pronto   = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        verificar("reset state", todasSaidas(), 64'd0);
        reset = 1'b0;

        // Primary success, secondary retry, no frontier, timeout, completion on the last cycle.
        transacao(8'd5, 8'd5, 8'd8, 8'd3, 10,    8'd0, 8'd0, 1,  0,  1'b0, -1);
        transacao(8'd5, 8'd5, 8'd5, 8'd5, 4,     8'd2, 8'd9, 6,  1,  1'b0, -1);
        transacao(8'd5, 8'd5, 8'd5, 8'd5, 3,     8'd5, 8'd5, 5,  0,  1'b0, -1);
        transacao(8'd7, 8'd1, 8'd9, 8'd9, NUNCA, 8'd0, 8'd0, 1,  0,  1'b0, -1);
        transacao(8'd7, 8'd1, 8'd9, 8'd9, T,     8'd0, 8'd0, 1,  0,  1'b0, -1);
        transacao(8'd7, 8'd7, 8'd7, 8'd7, 2,     8'd1, 8'd1, NUNCA, 0, 1'b0, -1);
        transacao(8'd7, 8'd7, 8'd7, 8'd7, 2,     8'd1, 8'd1, T,  0,  1'b0, -1);
        // Slow acceptance with stray pedido during the wait.
        transacao(8'd3, 8'd4, 8'd10, 8'd20, 5,   8'd0, 8'd0, 1,  20, 1'b1, -1);
        // Reset inside AGUARDAR, then a fresh request must start over with the primary mask.
        transacao(8'd5, 8'd5, 8'd8, 8'd3, 10,    8'd0, 8'd0, 1,  0,  1'b0, 6);
        transacao(8'd5, 8'd5, 8'd8, 8'd3, 10,    8'd0, 8'd0, 1,  0,  1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            px = 8'($urandom);
            py = 8'($urandom);
            n1 = $urandom_range(1, T + 3);
            n2 = $urandom_range(1, T + 3);
            if ($urandom_range(0, 2) == 0) begin r1x = px; r1y = py; end
            else begin r1x = 8'($urandom); r1y = 8'($urandom); end
            if ($urandom_range(0, 2) == 0) begin r2x = px; r2y = py; end
            else begin r2x = 8'($urandom); r2y = 8'($urandom); end
            resetEm = ($urandom_range(0, 9) == 0) ? 2 + $urandom_range(1, (n1 > T) ? T : n1) : -1;
            transacao(px, py, r1x, r1y, n1, r2x, r2y, n2, $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), resetEm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end
endmodule
